// File: rtl/mem_responder.sv
// mem_responder: single-port word memory behind a four-phase EN/MFC handshake.
// A request is captured in IDLE, waits LAT edges, then performs the access and
// holds MFC until the initiator drops mem_EN.
module mem_responder #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LAT    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_EN,
    input  logic              mem_RW,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              MFC,
    output logic              busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = 4;
    // LAT edges from capture to MFC: capture loads LAT-1, the cnt==0 edge completes.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_rw;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_mfc;
    logic                r_busy;
    logic [DATA_W-1:0]   r_mem [0:DEPTH-1];

    logic                w_fire;
    logic                w_mem_we;

    // Access completes on the WAIT edge where the countdown has expired and EN is still held.
    assign w_fire   = (r_state == S_WAIT) && mem_EN && (r_cnt == '0);
    assign w_mem_we = w_fire && !r_rw;

    // Handshake FSM with latched request, countdown and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_rw    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_mfc   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mem_EN) begin
                        r_addr  <= addr;
                        r_rw    <= mem_RW;
                        r_wdata <= wdata;
                        r_cnt   <= CNT_LOAD;
                        r_busy  <= 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!mem_EN) begin
                        // Abort: nothing is written and rdata is untouched.
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        if (r_rw) begin
                            r_rdata <= r_mem[r_addr];
                        end
                        r_mfc   <= 1'b1;
                        r_state <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (!mem_EN) begin
                        r_mfc   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_mfc   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Storage array; deliberately not reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    assign rdata = r_rdata;
    assign MFC   = r_mfc;
    assign busy  = r_busy;

endmodule

// File: tb/tb_mem_responder.sv
// Directed scoreboard bench for mem_responder.
module tb_mem_responder;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned LAT    = 3;

    logic              clk;
    logic              rst;
    logic              mem_EN;
    logic              mem_RW;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              MFC;
    logic              busy;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] model [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] sb_q [$];
    logic [DATA_W-1:0] last_rd;

    mem_responder #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .LAT   (LAT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .mem_EN(mem_EN),
        .mem_RW(mem_RW),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .MFC   (MFC),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Raise a request and run until MFC (bounded); checks latency and result.
    task automatic start_access(input logic rw, input logic [ADDR_W-1:0] a,
                                input logic [DATA_W-1:0] d, input bit scramble);
        int n;
        logic [DATA_W-1:0] exp;
        mem_EN = 1'b1;
        mem_RW = rw;
        addr   = a;
        wdata  = d;
        if (rw) sb_q.push_back(model[a]);
        tick();
        check("busy_after_capture", busy, 1);
        check("mfc_low_after_capture", MFC, 0);
        if (scramble) begin
            addr   = a ^ 8'h26;
            mem_RW = ~rw;
            wdata  = ~d;
        end
        n = 0;
        while (!MFC && n < 40) begin
            tick();
            n++;
        end
        check("mfc_latency", n, LAT);
        if (rw) begin
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
            check("rdata_on_mfc", rdata, exp);
            last_rd = exp;
        end else begin
            model[a] = d;
            check("rdata_kept_on_write", rdata, last_rd);
        end
    endtask

    // Hold EN one ACK cycle, then drop it and confirm return to IDLE.
    task automatic finish_access();
        tick();
        check("mfc_held_in_ack", MFC, 1);
        check("rdata_held_in_ack", rdata, last_rd);
        mem_EN = 1'b0;
        tick();
        check("mfc_drop", MFC, 0);
        check("busy_idle", busy, 0);
        check("rdata_held_idle", rdata, last_rd);
    endtask

    task automatic do_access(input logic rw, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d);
        start_access(rw, a, d, 1'b0);
        finish_access();
    endtask

    initial begin
        rst = 1'b0; mem_EN = 1'b0; mem_RW = 1'b0; addr = '0; wdata = '0;
        last_rd = '0;
        #12;
        check("reset_mfc", MFC, 0);
        check("reset_busy", busy, 0);
        check("reset_rdata", rdata, 0);

        // Idle noise with EN low must do nothing.
        mem_RW = 1'b1; addr = 8'h12;
        tick();
        rst = 1'b1;
        tick();
        tick();
        check("idle_noise_busy", busy, 0);
        check("idle_noise_mfc", MFC, 0);

        // Write then read back BEEF.
        do_access(1'b0, 8'h12, 16'hBEEF);
        do_access(1'b0, 8'h34, 16'h3434);
        do_access(1'b0, 8'h20, 16'h1111);
        do_access(1'b0, 8'h40, 16'hAAAA);
        do_access(1'b1, 8'h12, 16'h0000);

        // Inputs scrambled during WAIT are ignored.
        start_access(1'b1, 8'h12, 16'h0000, 1'b1);
        finish_access();
        do_access(1'b1, 8'h34, 16'h0000);

        // Abort a write after one WAIT cycle.
        mem_EN = 1'b1; mem_RW = 1'b0; addr = 8'h20; wdata = 16'h5555;
        tick();
        check("abort_busy_capture", busy, 1);
        tick();
        check("abort_mfc_wait", MFC, 0);
        mem_EN = 1'b0;
        tick();
        check("abort_mfc", MFC, 0);
        check("abort_busy", busy, 0);
        tick();
        check("abort_mfc_late", MFC, 0);
        check("abort_rdata", rdata, last_rd);
        do_access(1'b1, 8'h20, 16'h0000);

        // Reset during ACK clears outputs immediately.
        start_access(1'b1, 8'h12, 16'h0000, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("rst_ack_mfc", MFC, 0);
        check("rst_ack_busy", busy, 0);
        check("rst_ack_rdata", rdata, 0);
        last_rd = '0;
        mem_EN = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_idle", busy, 0);
        do_access(1'b1, 8'h12, 16'h0000);

        // Reset during WAIT of a write cancels the write.
        mem_EN = 1'b1; mem_RW = 1'b0; addr = 8'h40; wdata = 16'h9999;
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        check("rst_wait_busy", busy, 0);
        check("rst_wait_mfc", MFC, 0);
        last_rd = '0;
        mem_EN = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        do_access(1'b1, 8'h40, 16'h0000);

        // Back-to-back reads; finish_access already saw busy=0 between them.
        do_access(1'b1, 8'h12, 16'h0000);
        do_access(1'b1, 8'h20, 16'h0000);

        // Full-width address corner.
        do_access(1'b0, 8'hFF, 16'h7E57);
        do_access(1'b1, 8'hFF, 16'h0000);

        check("scoreboard_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning address width; storage depth is 2^ADDR_W words.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning data word width.
REQ-003 The block SHALL have parameter LAT, default 3, legal range 1..15, meaning wait cycles from request capture to MFC.
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-006 The block SHALL have port mem_EN  input  1  access request from the initiator; held high until MFC is seen.
REQ-007 The block SHALL have port mem_RW  input  1  access type: 1 = read, 0 = write.
REQ-008 The block SHALL have port addr  input  ADDR_W  word address from MAR.
REQ-009 The block SHALL have port wdata  input  DATA_W  write data from MDR.
REQ-010 The block SHALL have port rdata  output  DATA_W  registered read data toward MDR.
REQ-011 The block SHALL have port MFC  output  1  memory-function-complete acknowledge.
REQ-012 The block SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 The block SHALL implement a registered FSM with three states:
- IDLE
- WAIT
- ACK
REQ-014 In IDLE, on a clock edge with mem_EN=1, the block SHALL latch addr, mem_RW and wdata, load cnt=LAT-1, and enter WAIT.
REQ-015 In WAIT with mem_EN=1 and cnt!=0, the block SHALL decrement cnt at each edge and ignore all changes on addr, mem_RW and wdata.
REQ-016 In WAIT with mem_EN=1 and cnt=0, the block SHALL perform the latched access at that edge, set MFC=1 and enter ACK, so that MFC rises exactly LAT edges after the capture edge.
REQ-017 On a read, rdata SHALL update to mem[latched addr] at the same edge MFC rises and SHALL hold until the next read completes.
REQ-018 On a write, mem[latched addr] SHALL take the latched wdata at the same edge MFC rises, and rdata SHALL be left unchanged.
REQ-019 In ACK, the block SHALL hold MFC=1 while mem_EN=1; at the first edge sampling mem_EN=0 it SHALL clear MFC and enter IDLE (four-phase handshake).
REQ-020 If mem_EN is sampled 0 in WAIT (abort), the block SHALL return to IDLE with no memory write, no rdata change and MFC remaining 0.
REQ-021 Back-to-back access: a new request SHALL only be captured from IDLE, giving a minimum of one IDLE cycle between MFC falling and the next capture.
REQ-022 mem_RW and addr values in IDLE with mem_EN=0 SHALL have no effect.
REQ-023 Addresses SHALL use full ADDR_W width with no wrap or out-of-range case; all 2^ADDR_W words are accessible.
REQ-024 busy SHALL be 1 in WAIT and ACK, and 0 in IDLE.

Reset
REQ-025 While rst=0, the block SHALL immediately force state=IDLE, MFC=0, busy=0, rdata=0 and cnt=0, independent of clk.
REQ-026 Reset asserted mid-access (WAIT or ACK) SHALL cancel the access; a write whose MFC edge has not occurred SHALL NOT modify memory.
REQ-027 Memory array contents SHALL NOT be cleared by reset.
REQ-028 After rst rises, the first request SHALL be captured at the first edge with mem_EN=1.

Verification
REQ-029 The bench SHALL cover this scenario: write 0xBEEF to addr 0x12, LAT=3 -> MFC rises 3 edges after capture; mem_EN dropped -> MFC=0 next edge.
REQ-030 The bench SHALL cover this scenario: read addr 0x12 after the write -> rdata=0xBEEF on the MFC edge and held through ACK and after return to IDLE.
REQ-031 The bench SHALL cover this scenario: addr/mem_RW changed to 0x34/write during WAIT of a read of 0x12 -> read of 0x12 still returned, addr 0x34 unmodified.
REQ-032 The bench SHALL cover this scenario: mem_EN dropped after 1 WAIT cycle of a write of 0x5555 to 0x20 -> MFC never asserts, subsequent read of 0x20 returns the prior value.
REQ-033 The bench SHALL cover this scenario: rst pulsed low during ACK -> MFC=0, busy=0 and rdata=0 immediately; the next request completes normally with LAT latency.
REQ-034 The bench SHALL cover this scenario: two back-to-back reads with mem_EN re-raised the cycle after MFC falls -> second MFC rises LAT edges after the second capture, and busy=0 for at least one cycle in between.
